// File: rtl/memoria_ctrl.sv
// memoria_ctrl: round-robin arbiter driving the register file write port.
// The optional clear sweep is compiled in with MEMORIA_CTRL_CLEAR_EN.
module memoria_ctrl #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_req,
    input  logic [3:0]   a_sel,
    input  logic [N-1:0] a_data,
    output logic         a_gnt,
    input  logic         b_req,
    input  logic [3:0]   b_sel,
    input  logic [N-1:0] b_data,
    output logic         b_gnt,
    input  logic         clr_req,
    output logic         clr_busy,
    output logic         w,
    output logic [3:0]   select_register,
    output logic [N-1:0] s,
    output logic [7:0]   conflict_cnt
);

    logic       idle;
    logic       sweep;
    logic       clr_go;
    logic [3:0] idx;
    logic       prio_b;

`ifdef MEMORIA_CTRL_CLEAR_EN
    typedef enum logic {IDLE, SWEEP} state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (clr_req) state_d = SWEEP;
            SWEEP: if (idx_q == 4'hf) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= 4'h0;
        end else if (state_q == SWEEP) begin
            idx_q <= idx_q + 4'd1;
        end
    end

    assign idle   = (state_q == IDLE);
    assign sweep  = (state_q == SWEEP);
    assign clr_go = idle && clr_req;
    assign idx    = idx_q;
`else
    logic clr_unused;

    assign clr_unused = clr_req;
    assign idle       = 1'b1;
    assign sweep      = 1'b0;
    assign clr_go     = 1'b0;
    assign idx        = 4'h0;
`endif

    // prio_b low means A wins a tie
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst && idle && !clr_go) begin
            a_gnt = a_req && (!b_req || !prio_b);
            b_gnt = b_req && (!a_req || prio_b);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w               <= 1'b0;
            select_register <= 4'h0;
            s               <= '0;
            clr_busy        <= 1'b0;
            prio_b          <= 1'b0;
        end else begin
            w        <= sweep || a_gnt || b_gnt;
            clr_busy <= sweep;
            unique case (1'b1)
                sweep: begin
                    select_register <= idx;
                    s               <= '0;
                end
                a_gnt: begin
                    select_register <= a_sel;
                    s               <= a_data;
                end
                b_gnt: begin
                    select_register <= b_sel;
                    s               <= b_data;
                end
                default: ;
            endcase
            if (a_gnt) begin
                prio_b <= 1'b1;
            end else if (b_gnt) begin
                prio_b <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= 8'h00;
        end else if (idle && !clr_go && a_req && b_req
                     && conflict_cnt != 8'hff) begin
            conflict_cnt <= conflict_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_memoria_ctrl.sv
// tb_memoria_ctrl: randomized bench for memoria_ctrl against a transfer-level model.
// Sweep scenarios run when MEMORIA_CTRL_CLEAR_EN is defined.
module tb_memoria_ctrl;

    localparam int N = 16;
`ifdef MEMORIA_CTRL_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         a_req;
    logic [3:0]   a_sel;
    logic [N-1:0] a_data;
    logic         a_gnt;
    logic         b_req;
    logic [3:0]   b_sel;
    logic [N-1:0] b_data;
    logic         b_gnt;
    logic         clr_req;
    logic         clr_busy;
    logic         w;
    logic [3:0]   select_register;
    logic [N-1:0] s;
    logic [7:0]   conflict_cnt;

    int errors;
    int checks;

    memoria_ctrl #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .a_req(a_req),
        .a_sel(a_sel),
        .a_data(a_data),
        .a_gnt(a_gnt),
        .b_req(b_req),
        .b_sel(b_sel),
        .b_data(b_data),
        .b_gnt(b_gnt),
        .clr_req(clr_req),
        .clr_busy(clr_busy),
        .w(w),
        .select_register(select_register),
        .s(s),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file attached to the write port
    logic [N-1:0] dut_rf [16];
    always @(posedge clk) if (w) dut_rf[select_register] <= s;

    // model state
    logic         m_prio_b;
    logic [7:0]   m_cnt;
    logic         m_w;
    logic [3:0]   m_sel;
    logic [N-1:0] m_s;
    logic         m_busy;
    int           m_swp;
    logic [N-1:0] exp_rf [16];
    bit           exp_v [16];

    task automatic model_reset();
        m_prio_b = 1'b0;
        m_cnt    = 8'h00;
        m_w      = 1'b0;
        m_sel    = 4'h0;
        m_s      = '0;
        m_busy   = 1'b0;
        m_swp    = -1;
    endtask

    function automatic logic exp_ga();
        if (!rst || m_swp >= 0 || (CLR_EN && clr_req)) return 1'b0;
        return a_req && (!b_req || !m_prio_b);
    endfunction

    function automatic logic exp_gb();
        if (!rst || m_swp >= 0 || (CLR_EN && clr_req)) return 1'b0;
        return b_req && (!a_req || m_prio_b);
    endfunction

    task automatic tick();
        logic ga;
        logic gb;
        ga = exp_ga();
        gb = exp_gb();
        @(posedge clk);
        if (m_w) begin
            exp_rf[m_sel] = m_s;
            exp_v[m_sel]  = 1'b1;
        end
        if (m_swp >= 0) begin
            m_w    = 1'b1;
            m_sel  = m_swp[3:0];
            m_s    = '0;
            m_busy = 1'b1;
            m_swp  = (m_swp == 15) ? -1 : m_swp + 1;
        end else begin
            m_busy = 1'b0;
            m_w    = ga || gb;
            if (ga) begin
                m_sel    = a_sel;
                m_s      = a_data;
                m_prio_b = 1'b1;
            end else if (gb) begin
                m_sel    = b_sel;
                m_s      = b_data;
                m_prio_b = 1'b0;
            end
            if (a_req && b_req && !(CLR_EN && clr_req) && m_cnt != 8'hff)
                m_cnt = m_cnt + 8'd1;
            if (CLR_EN && clr_req) m_swp = 0;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst     = 1'b0;
        a_req   = 1'b0;
        b_req   = 1'b0;
        clr_req = 1'b0;
        #3;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        a_req   = 1'b1;
        a_sel   = 4'd3;
        a_data  = 16'h1234;
        b_req   = 1'b0;
        b_sel   = 4'd0;
        b_data  = '0;
        clr_req = 1'b0;
        #2;
        checks++;
        if ({w, select_register, s, clr_busy, conflict_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outs got %h want 0",
                     {w, select_register, s, clr_busy, conflict_cnt});
        end
        checks++;
        if (a_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt got %b want 0", a_gnt);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL first_gnt got %b want 1", a_gnt);
        end
        tick();
        checks++;
        if ({w, select_register, s} !== {1'b1, 4'd3, 16'h1234}) begin
            errors++;
            $display("FAIL first_write got %h want %h",
                     {w, select_register, s}, {1'b1, 4'd3, 16'h1234});
        end
        a_req = 1'b0;
        tick();
        tick();
        checks++;
        if (dut_rf[3] !== 16'h1234) begin
            errors++;
            $display("FAIL rf3 got %h want 1234", dut_rf[3]);
        end
    endtask

    task automatic test_alternate();
        logic ga;
        logic gb;
        int   wcnt;
        wcnt   = 0;
        a_req  = 1'b1;
        b_req  = 1'b1;
        a_sel  = 4'd1;
        b_sel  = 4'd2;
        a_data = N'($urandom);
        b_data = N'($urandom);
        for (int i = 0; i < 4; i++) begin
            #1;
            ga = exp_ga();
            gb = exp_gb();
            checks++;
            if ({a_gnt, b_gnt} !== {ga, gb}) begin
                errors++;
                $display("FAIL alt_gnt%0d got %b want %b", i, {a_gnt, b_gnt}, {ga, gb});
            end
            tick();
            if (w === 1'b1) wcnt++;
            checks++;
            if ({w, select_register, s, clr_busy, conflict_cnt}
                !== {m_w, m_sel, m_s, m_busy, m_cnt}) begin
                errors++;
                $display("FAIL alt_outs%0d got %h want %h", i,
                         {w, select_register, s, clr_busy, conflict_cnt},
                         {m_w, m_sel, m_s, m_busy, m_cnt});
            end
            if (i == 2) begin
                checks++;
                if (conflict_cnt !== 8'd3) begin
                    errors++;
                    $display("FAIL alt_cnt got %0d want 3", conflict_cnt);
                end
            end
            if (ga) a_data = N'($urandom);
            if (gb) b_data = N'($urandom);
        end
        checks++;
        if (wcnt != 4) begin
            errors++;
            $display("FAIL alt_wcount got %0d want 4", wcnt);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
    endtask

    task automatic test_same_index();
        apply_reset();
        a_req  = 1'b1;
        b_req  = 1'b1;
        a_sel  = 4'd5;
        b_sel  = 4'd5;
        a_data = 16'h00aa;
        b_data = 16'h00bb;
        #1;
        checks++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL same_gnt1 got %b want 10", {a_gnt, b_gnt});
        end
        tick();
        checks++;
        if ({w, select_register, s} !== {1'b1, 4'd5, 16'h00aa}) begin
            errors++;
            $display("FAIL same_w1 got %h want %h",
                     {w, select_register, s}, {1'b1, 4'd5, 16'h00aa});
        end
        a_req = 1'b0;
        #1;
        checks++;
        if ({a_gnt, b_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL same_gnt2 got %b want 01", {a_gnt, b_gnt});
        end
        tick();
        checks++;
        if ({w, select_register, s} !== {1'b1, 4'd5, 16'h00bb}) begin
            errors++;
            $display("FAIL same_w2 got %h want %h",
                     {w, select_register, s}, {1'b1, 4'd5, 16'h00bb});
        end
        b_req = 1'b0;
        tick();
        tick();
        checks++;
        if (dut_rf[5] !== 16'h00bb) begin
            errors++;
            $display("FAIL same_rf5 got %h want 00bb", dut_rf[5]);
        end
    endtask

    task automatic test_random();
        logic ga;
        logic gb;
        ga = 1'b0;
        gb = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!a_req || ga) begin
                a_req  = 1'($urandom_range(0, 1));
                a_sel  = 4'($urandom);
                a_data = N'($urandom);
            end
            if (!b_req || gb) begin
                b_req  = 1'($urandom_range(0, 1));
                b_sel  = 4'($urandom);
                b_data = N'($urandom);
            end
            #1;
            ga = exp_ga();
            gb = exp_gb();
            checks++;
            if ({a_gnt, b_gnt} !== {ga, gb}) begin
                errors++;
                $display("FAIL rnd_gnt%0d got %b want %b", i, {a_gnt, b_gnt}, {ga, gb});
            end
            tick();
            checks++;
            if ({w, select_register, s, clr_busy, conflict_cnt}
                !== {m_w, m_sel, m_s, m_busy, m_cnt}) begin
                errors++;
                $display("FAIL rnd_outs%0d got %h want %h", i,
                         {w, select_register, s, clr_busy, conflict_cnt},
                         {m_w, m_sel, m_s, m_busy, m_cnt});
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        tick();
        for (int r = 0; r < 16; r++) begin
            if (exp_v[r]) begin
                checks++;
                if (dut_rf[r] !== exp_rf[r]) begin
                    errors++;
                    $display("FAIL rnd_rf%0d got %h want %h", r, dut_rf[r], exp_rf[r]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        a_req = 1'b1;
        b_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (exp_ga()) a_data = N'($urandom);
            if (exp_gb()) b_data = N'($urandom);
            tick();
        end
        checks++;
        if (conflict_cnt !== 8'd255 || m_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_cnt got %0d want 255", conflict_cnt);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
    endtask

`ifdef MEMORIA_CTRL_CLEAR_EN
    task automatic test_sweep();
        int busy_cycles;
        busy_cycles = 0;
        a_req   = 1'b1;
        a_sel   = 4'd9;
        a_data  = 16'h5a5a;
        b_req   = 1'b0;
        clr_req = 1'b1;
        #1;
        checks++;
        if (a_gnt !== 1'b0) begin
            errors++;
            $display("FAIL swp_gate got %b want 0", a_gnt);
        end
        tick();
        clr_req = 1'b0;
        checks++;
        if ({w, clr_busy} !== 2'b00) begin
            errors++;
            $display("FAIL swp_start got %b want 00", {w, clr_busy});
        end
        for (int i = 0; i < 16; i++) begin
            clr_req = (i == 5);
            #1;
            checks++;
            if ({a_gnt, b_gnt} !== 2'b00) begin
                errors++;
                $display("FAIL swp_gnt%0d got %b want 00", i, {a_gnt, b_gnt});
            end
            tick();
            if (clr_busy === 1'b1) busy_cycles++;
            checks++;
            if ({w, select_register, s} !== {1'b1, 4'(i), 16'h0000}
                || {w, select_register, s, clr_busy} !== {m_w, m_sel, m_s, m_busy}) begin
                errors++;
                $display("FAIL swp_w%0d got %h want %h", i,
                         {w, select_register, s}, {1'b1, 4'(i), 16'h0000});
            end
        end
        clr_req = 1'b0;
        #1;
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL swp_after_gnt got %b want 1", a_gnt);
        end
        tick();
        if (clr_busy === 1'b1) busy_cycles++;
        checks++;
        if ({w, select_register, s} !== {1'b1, 4'd9, 16'h5a5a}) begin
            errors++;
            $display("FAIL swp_after_w got %h want %h",
                     {w, select_register, s}, {1'b1, 4'd9, 16'h5a5a});
        end
        checks++;
        if (busy_cycles != 16) begin
            errors++;
            $display("FAIL swp_busy got %0d want 16", busy_cycles);
        end
        a_req = 1'b0;
        tick();
        tick();
        for (int r = 0; r < 16; r++) begin
            checks++;
            if (dut_rf[r] !== ((r == 9) ? 16'h5a5a : 16'h0000)) begin
                errors++;
                $display("FAIL swp_rf%0d got %h", r, dut_rf[r]);
            end
        end
    endtask

    task automatic test_sweep_reset();
        b_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_req  = 1'b1;
            a_sel  = 4'(i);
            a_data = N'($urandom) | 16'h0001;
            tick();
        end
        a_req   = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({w, clr_busy} !== 2'b00) begin
            errors++;
            $display("FAIL swprst_outs got %b want 00", {w, clr_busy});
        end
        model_reset();
        #2;
        rst = 1'b1;
        tick();
        tick();
        for (int r = 0; r < 16; r++) begin
            checks++;
            if (dut_rf[r] !== exp_rf[r] || (r < 7) != (exp_rf[r] == '0)) begin
                errors++;
                $display("FAIL swprst_rf%0d got %h want %h", r, dut_rf[r], exp_rf[r]);
            end
        end
    endtask
`else
    task automatic test_no_clear();
        int busy_cycles;
        logic ga;
        busy_cycles = 0;
        a_req   = 1'b1;
        a_sel   = 4'd11;
        a_data  = 16'hc0de;
        b_req   = 1'b0;
        clr_req = 1'b1;
        #1;
        ga = exp_ga();
        checks++;
        if (a_gnt !== 1'b1 || ga !== 1'b1) begin
            errors++;
            $display("FAIL noclr_gnt got %b want 1", a_gnt);
        end
        tick();
        clr_req = 1'b0;
        a_req   = 1'b0;
        checks++;
        if ({w, select_register, s} !== {1'b1, 4'd11, 16'hc0de}) begin
            errors++;
            $display("FAIL noclr_w got %h want %h",
                     {w, select_register, s}, {1'b1, 4'd11, 16'hc0de});
        end
        for (int i = 0; i < 18; i++) begin
            tick();
            if (clr_busy !== 1'b0 || w !== 1'b0) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 0) begin
            errors++;
            $display("FAIL noclr_busy got %0d want 0", busy_cycles);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        for (int r = 0; r < 16; r++) exp_v[r] = 1'b0;
        model_reset();
        test_reset();
        test_alternate();
        test_same_index();
        test_random();
        test_saturate();
`ifdef MEMORIA_CTRL_CLEAR_EN
        test_sweep();
        test_sweep_reset();
`else
        test_no_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
